// File: rtl/lutram_write_scheduler.sv
// Write-port owner for a 1W/1R LUTRAM: clears every entry after reset or on request,
// then round-robins the port between requesters A and B, with write-to-read forwarding.
module lutram_write_scheduler #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int                   ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_req,
    output logic                  init_busy,
    input  logic                  a_req,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ack,
    input  logic                  b_req,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ack,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  ram_write,
    output logic [ADDR_W-1:0]     ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_W-1:0]     ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              rr_pref;

    logic in_run;
    logic grant_a;
    logic grant_b;

    assign in_run  = (state == ST_RUN);
    // rr_pref picks the winner only on contention; a lone requester always wins.
    assign grant_a = in_run && a_req && (!b_req || !rr_pref);
    assign grant_b = in_run && b_req && !grant_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            cnt     <= '0;
            rr_pref <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_req) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (grant_a)
                        rr_pref <= 1'b1;
                    else if (grant_b)
                        rr_pref <= 1'b0;
                    if (init_req) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        ram_write = 1'b1;
        ram_waddr = cnt;
        ram_wdata = INIT_VALUE;
        if (in_run) begin
            ram_write = grant_a | grant_b;
            ram_waddr = grant_a ? a_addr : b_addr;
            ram_wdata = grant_a ? a_data : b_data;
        end
    end

    assign init_busy = !in_run;
    assign rd_valid  = in_run;
    assign a_ack     = grant_a;
    assign b_ack     = grant_b;
    assign ram_raddr = rd_addr;

    // The RAM read is asynchronous but the write lands on the next edge, so bypass it.
    assign rd_data = (ram_write && (ram_waddr == rd_addr)) ? ram_wdata : ram_rdata;

endmodule

// File: tb/tb_lutram_write_scheduler.sv
// Bench for lutram_write_scheduler: DEPTH=32 instance checked against a cycle model and a
// write scoreboard; a DEPTH=20 instance with nonzero INIT_VALUE checks sweep range and reset.
module tb_lutram_write_scheduler;

    localparam logic [31:0] INIT20 = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        init_req;
    logic        a_req, b_req;
    logic [4:0]  a_addr, b_addr, rd_addr;
    logic [31:0] a_data, b_data;

    logic        busy32, aack32, back32, rdv32, w32;
    logic [4:0]  wa32, ra32;
    logic [31:0] wd32, rdd32, rrd32;
    logic        busy20, aack20, back20, rdv20, w20;
    logic [4:0]  wa20, ra20;
    logic [31:0] wd20, rdd20, rrd20;

    logic [31:0] mem32 [32];
    logic [31:0] mem20 [32];

    lutram_write_scheduler #(.DATA_WIDTH(32), .DEPTH(32), .INIT_VALUE(32'h0)) u32 (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_busy(busy32),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(aack32),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(back32),
        .rd_addr(rd_addr), .rd_data(rdd32), .rd_valid(rdv32),
        .ram_write(w32), .ram_waddr(wa32), .ram_wdata(wd32),
        .ram_raddr(ra32), .ram_rdata(rrd32));

    lutram_write_scheduler #(.DATA_WIDTH(32), .DEPTH(20), .INIT_VALUE(INIT20)) u20 (
        .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_busy(busy20),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(aack20),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(back20),
        .rd_addr(rd_addr), .rd_data(rdd20), .rd_valid(rdv20),
        .ram_write(w20), .ram_waddr(wa20), .ram_wdata(wd20),
        .ram_raddr(ra20), .ram_rdata(rrd20));

    // Behavioural LUTRAMs: async read, write on posedge.
    assign rrd32 = mem32[ra32];
    assign rrd20 = mem20[ra20];
    always @(posedge clk) begin
        if (w32) mem32[wa32] <= wd32;
        if (w20) mem20[wa20] <= wd20;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t q[$];
    wr_t e;

    // Scoreboard: every granted RUN-mode write must match the next expected one.
    always @(negedge clk) begin
        #2;
        if (rst_n && w32 && !busy32) begin
            chk("wr_pending", q.size() > 0, 1'b1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wr_addr", wa32, e.addr);
                chk("wr_data", wd32, e.data);
            end
        end
    end

    // Reference model state
    logic [31:0] m_mem [32];
    logic        m_busy, m_rr, m_busy20;
    logic [4:0]  m_cnt, m_cnt20;
    logic        last_ga, last_gb;
    logic        rd20_chk;

    task automatic cyc();
        logic ga, gb, ew;
        logic [4:0]  ewa;
        logic [31:0] ewd, erd;
        @(negedge clk);
        ga  = !m_busy && a_req && (!b_req || !m_rr);
        gb  = !m_busy && b_req && !ga;
        ew  = m_busy || ga || gb;
        ewa = m_busy ? m_cnt : (ga ? a_addr : b_addr);
        ewd = m_busy ? 32'h0 : (ga ? a_data : b_data);
        erd = (ew && ewa == rd_addr) ? ewd : m_mem[rd_addr];
        chk("init_busy", busy32, m_busy);
        chk("rd_valid", rdv32, !m_busy);
        chk("a_ack", aack32, ga);
        chk("b_ack", back32, gb);
        chk("ram_write", w32, ew);
        if (ew) begin
            chk("ram_waddr", wa32, ewa);
            chk("ram_wdata", wd32, ewd);
        end
        chk("ram_raddr", ra32, rd_addr);
        chk("rd_data", rdd32, erd);
        if (ga || gb) q.push_back(wr_t'{ewa, ewd});

        chk("busy20", busy20, m_busy20);
        if (m_busy20) begin
            chk("write20", w20, 1'b1);
            chk("waddr20", wa20, m_cnt20);
            chk("wdata20", wd20, INIT20);
            chk("ack20", {aack20, back20}, 2'b00);
        end else begin
            chk("rd_valid20", rdv20, 1'b1);
            if (rd20_chk) chk("rd_data20", rdd20, INIT20);
        end

        if (ew) m_mem[ewa] = ewd;
        if (m_busy) begin
            if (init_req) m_cnt = 0;
            else if (m_cnt == 5'd31) begin m_busy = 0; m_cnt = 0; end
            else m_cnt++;
        end else begin
            if (ga) m_rr = 1;
            else if (gb) m_rr = 0;
            if (init_req) begin m_busy = 1; m_cnt = 0; end
        end
        if (m_busy20) begin
            if (init_req) m_cnt20 = 0;
            else if (m_cnt20 == 5'd19) begin m_busy20 = 0; m_cnt20 = 0; end
            else m_cnt20++;
        end else if (init_req) begin
            m_busy20 = 1;
            m_cnt20  = 0;
        end
        last_ga = ga;
        last_gb = gb;
        @(posedge clk);
        #1;
    endtask

    task automatic hit_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy32, 1'b1);
        chk("rst_write", w32, 1'b1);
        chk("rst_waddr", wa32, 5'd0);
        chk("rst_wdata", wd32, 32'h0);
        chk("rst_acks", {aack32, back32}, 2'b00);
        chk("rst_rd_valid", rdv32, 1'b0);
        chk("rst_busy20", busy20, 1'b1);
        chk("rst_write20", w20, 1'b1);
        chk("rst_waddr20", wa20, 5'd0);
        chk("rst_wdata20", wd20, INIT20);
        chk("rst_rd_valid20", rdv20, 1'b0);
        @(posedge clk);
        #1;
        m_mem[0] = 32'h0;
        m_busy = 1; m_cnt = 0; m_rr = 0;
        m_busy20 = 1; m_cnt20 = 0;
        rst_n = 1'b1;
    endtask

    logic [3:0] seq;

    initial begin
        rst_n = 0; init_req = 0; a_req = 0; b_req = 0;
        a_addr = 0; b_addr = 0; a_data = 0; b_data = 0; rd_addr = 0;
        rd20_chk = 0;
        for (int i = 0; i < 32; i++) begin
            mem32[i] = 32'h5A5A_5A5A ^ (i * 32'h0101_0101);
            m_mem[i] = 32'h5A5A_5A5A ^ (i * 32'h0101_0101);
            mem20[i] = 32'hC3C3_0000 + i;
        end

        // Power-up sweep, reading along behind the sweep pointer
        hit_reset();
        rd20_chk = 1;
        for (int i = 0; i < 33; i++) begin
            rd_addr = 5'(i % 20);
            cyc();
        end
        rd20_chk = 0;

        // Every DEPTH=32 entry now reads INIT_VALUE
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            cyc();
        end

        // A alone: forwarded the same cycle, from RAM the next
        a_req = 1; a_addr = 5; a_data = 32'hDEAD_BEEF; rd_addr = 5;
        cyc();
        a_req = 0;
        cyc();
        chk("a5_readback", rdd32, 32'hDEAD_BEEF);

        // B alone to return preference to A, then contention for 4 cycles
        b_req = 1; b_addr = 3; b_data = 32'h0B0B_0003;
        cyc();
        a_req = 1; a_addr = 12; a_data = 32'h1111_0000;
        b_req = 1; b_addr = 20; b_data = 32'h2222_0000;
        rd_addr = 12;
        seq = '0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            seq = {seq[2:0], last_gb};
            if (last_ga) begin a_addr++; a_data++; end
            if (last_gb) begin b_addr++; b_data++; end
        end
        chk("rr_order", seq, 4'b0101);
        a_req = 0; b_req = 0;
        rd_addr = 13;
        cyc();

        // init_req while B requests: B acked now, then starved for the whole sweep
        b_req = 1; b_addr = 9; b_data = 32'h9999_0001; init_req = 1;
        cyc();
        chk("b_ack_on_init", last_gb, 1'b1);
        init_req = 0; b_addr = 10; b_data = 32'h9999_0002;
        for (int i = 0; i < 34; i++) begin
            rd_addr = 5'(i);
            cyc();
            if (last_gb) b_req = 0;
        end
        chk("b_req_served", b_req, 1'b0);

        // Restart the sweep at counter 10
        init_req = 1;
        cyc();
        init_req = 0;
        for (int i = 0; i < 10; i++) cyc();
        init_req = 1;
        cyc();
        init_req = 0;
        for (int i = 0; i < 33; i++) begin
            rd_addr = 5'(31 - i);
            cyc();
        end

        // Async reset at counter 7 with a request pending, then a full fresh sweep
        hit_reset();
        for (int i = 0; i < 7; i++) cyc();
        a_req = 1; a_addr = 17; a_data = 32'h7777_0017;
        hit_reset();
        rd20_chk = 1;
        for (int i = 0; i < 33; i++) begin
            rd_addr = 5'((i + 3) % 20);
            cyc();
            if (last_ga) begin a_req = 0; rd20_chk = 0; end
        end
        chk("a_req_served", a_req, 1'b0);
        rd_addr = 17;
        cyc();
        chk("a17_readback", rdd32, 32'h7777_0017);

        cyc();
        chk("wr_q_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lutram_write_scheduler.md
Name: lutram_write_scheduler

Overview:
- Owns the single write port of a distributed-RAM (LUTRAM) 1-write/1-read memory.
- After reset, or on request, sequences a full clear sweep. Otherwise shares the write port between two requesters (A, B) using round-robin arbitration.
- Also drives the read address and returns read data with same-cycle write forwarding.
- Sits directly in front of the LUTRAM inside structures such as tag/state tables.

Parameters:
- DATA_WIDTH, 32, width of each RAM entry.
- DEPTH, 32, number of entries. Need not be a power of two. ADDR_W = $clog2(DEPTH).
- INIT_VALUE, '0, DATA_WIDTH value written to every entry during a clear sweep.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- init_req  in  1  one-cycle pulse: (re)start clear sweep
- init_busy  out  1  high while clear sweep in progress
- a_req  in  1  requester A write request
- a_addr  in  ADDR_W  A write address
- a_data  in  DATA_WIDTH  A write data
- a_ack  out  1  A write accepted this cycle
- b_req  in  1  requester B write request
- b_addr  in  ADDR_W  B write address
- b_data  in  DATA_WIDTH  B write data
- b_ack  out  1  B write accepted this cycle
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_WIDTH  read data, forwarded
- rd_valid  out  1  rd_data meaningful (not in sweep)
- ram_write  out  1  to RAM write enable
- ram_waddr  out  ADDR_W  to RAM write address
- ram_wdata  out  DATA_WIDTH  to RAM write data
- ram_raddr  out  ADDR_W  to RAM read address (= rd_addr)
- ram_rdata  in  DATA_WIDTH  from RAM asynchronous read data

Behaviour:
- FSM states: INIT, RUN. Registered state: FSM state, sweep counter (ADDR_W bits), rr_pref (0 = prefer A, 1 = prefer B).
- Reset (rst_n low, async): state=INIT, counter=0, rr_pref=0.
- Outputs while in reset: init_busy=1, ram_write=1, ram_waddr=0, ram_wdata=INIT_VALUE, a_ack=b_ack=0, rd_valid=0.
- INIT:
  - ram_write=1, ram_waddr=counter, ram_wdata=INIT_VALUE; acks 0; init_busy=1; rd_valid=0.
  - Each cycle: counter+1. When counter==DEPTH-1, the next state is RUN and counter goes to 0.
  - A sweep therefore takes exactly DEPTH cycles.
  - init_req during INIT: counter restarts at 0 next cycle (full sweep again).
- RUN:
  - init_busy=0, rd_valid=1.
  - init_req: next state INIT, counter=0. In the init_req cycle, arbitration still proceeds normally.
- Arbitration (RUN only, combinational grant, same-cycle ack):
  - Only a_req: grant A. Only b_req: grant B.
  - Both: grant A if rr_pref=0, else B.
  - On grant: ram_write=1, ram_waddr/ram_wdata = granted requester's addr/data, ack of that requester=1. rr_pref <= (granted==A) next cycle.
  - No request: ram_write=0, rr_pref unchanged.
- Handshake:
  - Requester holds req/addr/data stable until ack. Write is committed on the posedge that ends the ack cycle. Deasserting req without ack is permitted (request withdrawn).
  - A granted write is visible on ram_rdata from the following cycle.
- Read:
  - ram_raddr = rd_addr.
  - rd_data = new_data if (ram_write && ram_waddr==rd_addr), else ram_rdata, where new_data = the ram_wdata value being written this cycle. Forwarding applies in INIT too, but rd_valid=0 there.
- Reset mid-sweep or mid-handshake: the pending request is dropped (no ack). The sweep restarts from 0 after rst_n release.
- No write outside the address range: the counter never exceeds DEPTH-1. Requester addresses ≥DEPTH are a caller error and are passed through unchecked.

Test Plan:
- Release rst_n, DEPTH=32, INIT_VALUE=0 -> init_busy high for exactly 32 posedges, ram_waddr 0..31 with ram_write=1; RUN on the 33rd cycle; all 32 entries read 0.
- RUN, a_req only, addr 5, data 0xDEAD_BEEF -> a_ack same cycle; rd_addr=5 gives 0xDEADBEEF that cycle (forwarded) and the next cycle (RAM).
- a_req and b_req held high 4 cycles from rr_pref=0 -> acks A,B,A,B; writes land at each requester's addr in that order.
- RUN, init_req pulse while b_req high -> b_ack that cycle; next cycle init_busy=1 and b_ack=0 for 32 cycles even with b_req held; then B is acked.
- init_req at sweep counter=10 -> counter returns to 0; init_busy stays high 32 more cycles.
- DEPTH=20: sweep covers 0..19 only, 20 cycles; rst_n asserted at counter=7 -> outputs take their reset values immediately; after release, a full 20-cycle sweep.
